lfrs_chk: RTL and testbench



---
 rtl/lfrs_pkg.sv | 25 ++
 rtl/lfrs_chk.sv | 122 ++++++++++++
 tb/tb_lfrs_chk.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfrs_pkg.sv
// Shared definitions for the 5-bit LFSR pattern generator and its receive-side checker.
// Both sides call lfrs_next so the transmitted and predicted sequences cannot diverge.
package lfrs_pkg;

    localparam int LFRS_W = 5;
    localparam int OUT_W  = 4;

    localparam logic [LFRS_W-1:0] GEN_SEED = 5'h1f;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SEED   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // One step of the generator recurrence; the emitted word is state[4:1].
    function automatic logic [LFRS_W-1:0] lfrs_next(input logic [LFRS_W-1:0] a);
        lfrs_next = {a[0],
                     a[4] ^ a[1],
                     a[3] ^ a[0],
                     a[2] ^ a[4] ^ a[1],
                     a[1] ^ a[3] ^ a[0]};
    endfunction

endpackage

// File: rtl/lfrs_chk.sv
// Receive-side checker: self-synchronises to the 4-bit LFSR word stream from any phase,
// then predicts every word, counts mismatches and drops back to HUNT after a run of errors.
module lfrs_chk
    import lfrs_pkg::*;
#(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_vld,
    input  logic [OUT_W-1:0] din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MISS_W = 4;

    chk_state_t        state_q, state_d;
    logic [LFRS_W-1:0] s_q, s_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic              sync_lost_q, sync_lost_d;

    logic              mismatch;
    logic [LFRS_W-1:0] cand;
    logic [LFRS_W-1:0] cand_nxt;
    logic [MISS_W-1:0] miss_inc;

    // Candidate generator state from the stored word plus the MSB of the new word;
    // its successor must reproduce the whole new word for the pair to be consistent.
    assign cand     = {s_q[LFRS_W-1:1], din[OUT_W-1]};
    assign cand_nxt = lfrs_next(cand);
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        sync_lost_d = 1'b0;
        mismatch    = 1'b0;

        if (din_vld) begin
            unique case (state_q)
                HUNT: begin
                    s_d     = {din, 1'b0};
                    state_d = SEED;
                end
                SEED: begin
                    if (cand != '0 && din == cand_nxt[LFRS_W-1:1]) begin
                        s_d     = lfrs_next(cand_nxt);
                        state_d = LOCKED;
                    end else begin
                        s_d = {din, 1'b0};
                    end
                end
                LOCKED: begin
                    s_d      = lfrs_next(s_q);
                    mismatch = (din != s_q[LFRS_W-1:1]);
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                            state_d     = HUNT;
                            sync_lost_d = 1'b1;
                            miss_d      = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // The clear wins over saturation but still records a coincident mismatch.
        if (clr_cnt) begin
            err_cnt_d = mismatch ? CNT_W'(1) : '0;
        end else if (mismatch && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        locked_d = (state_d == LOCKED);
    end

    // NOTE: asynchronous active-low reset; all state including the prediction register is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            s_q         <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            s_q         <= s_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign sync_lost = sync_lost_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfrs_chk.sv
// Self-checking bench for lfrs_chk: directed scenarios plus randomized traffic,
// compared against a word-level behavioural model of the checker.
module tb_lfrs_chk;
    import lfrs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance 0: default parameters. Instance 1: narrow counter, loss disabled in practice.
    logic       vld0 = 1'b0, clr0 = 1'b0;
    logic [3:0] din0 = '0;
    logic       locked0, err_pulse0, sync_lost0;
    logic [15:0] err_cnt0;

    logic       vld1 = 1'b0, clr1 = 1'b0;
    logic [3:0] din1 = '0;
    logic       locked1, err_pulse1, sync_lost1;
    logic [1:0] err_cnt1;

    int total = 0;
    int bad   = 0;

    lfrs_chk #(.LOSS_THRESH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din_vld(vld0), .din(din0), .clr_cnt(clr0),
        .locked(locked0), .err_pulse(err_pulse0), .sync_lost(sync_lost0), .err_cnt(err_cnt0)
    );

    lfrs_chk #(.LOSS_THRESH(15), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .din_vld(vld1), .din(din1), .clr_cnt(clr1),
        .locked(locked1), .err_pulse(err_pulse1), .sync_lost(sync_lost1), .err_cnt(err_cnt1)
    );

    always #5 clk = ~clk;

    // Reference model state, one entry per instance. Mode: 0 hunt, 1 seed, 2 locked.
    int         m_mode[2];
    logic [4:0] m_pred[2];
    int         m_miss[2];
    int         m_cnt[2];
    bit         m_err[2];
    bit         m_sl[2];
    int         m_thr[2] = '{4, 15};
    int         m_max[2] = '{65535, 3};
    logic [4:0] g[2];

    // Generator recurrence written bit by bit from its definition.
    function automatic logic [4:0] nx(input logic [4:0] a);
        logic [4:0] r;
        r[4] = a[0];
        r[3] = a[4] ^ a[1];
        r[2] = a[3] ^ a[0];
        r[1] = a[2] ^ a[4] ^ a[1];
        r[0] = a[1] ^ a[3] ^ a[0];
        return r;
    endfunction

    function automatic logic [3:0] rnd_mask();
        return 4'($urandom_range(1, 15));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_pred[k] = '0; m_miss[k] = 0;
            m_cnt[k] = 0; m_err[k] = 0; m_sl[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [3:0] d, input bit c);
        bit mm;
        logic [4:0] a, an;
        mm = 0;
        m_err[k] = 0;
        m_sl[k]  = 0;
        if (v) begin
            case (m_mode[k])
                0: begin
                    m_pred[k] = {d, 1'b0};
                    m_mode[k] = 1;
                end
                1: begin
                    a  = {m_pred[k][4:1], d[3]};
                    an = nx(a);
                    if (a != 0 && d[2:0] == an[3:1]) begin
                        m_pred[k] = nx(an);
                        m_mode[k] = 2;
                    end else begin
                        m_pred[k] = {d, 1'b0};
                    end
                end
                default: begin
                    mm = (d != m_pred[k][4:1]);
                    m_pred[k] = nx(m_pred[k]);
                    if (mm) begin
                        m_err[k] = 1;
                        m_miss[k]++;
                        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                        if (m_miss[k] == m_thr[k]) begin
                            m_mode[k] = 0;
                            m_sl[k]   = 1;
                            m_miss[k] = 0;
                        end
                    end else begin
                        m_miss[k] = 0;
                    end
                end
            endcase
        end
        if (c) m_cnt[k] = mm ? 1 : 0;
    endtask

    task automatic compare(input int k);
        if (k == 0) begin
            check("locked0",    32'(locked0),    32'(m_mode[0] == 2));
            check("err_pulse0", 32'(err_pulse0), 32'(m_err[0]));
            check("sync_lost0", 32'(sync_lost0), 32'(m_sl[0]));
            check("err_cnt0",   32'(err_cnt0),   32'(m_cnt[0]));
        end else begin
            check("locked1",    32'(locked1),    32'(m_mode[1] == 2));
            check("err_pulse1", 32'(err_pulse1), 32'(m_err[1]));
            check("sync_lost1", 32'(sync_lost1), 32'(m_sl[1]));
            check("err_cnt1",   32'(err_cnt1),   32'(m_cnt[1]));
        end
    endtask

    // Drive one cycle on instance k (the other instance idles), then check after the edge.
    task automatic step(input int k, input bit v, input logic [3:0] d, input bit c);
        if (k == 0) begin
            vld0 = v; din0 = d; clr0 = c; vld1 = 0; clr1 = 0;
        end else begin
            vld1 = v; din1 = d; clr1 = c; vld0 = 0; clr0 = 0;
        end
        model_step(k, v, d, c);
        @(posedge clk);
        #1;
        compare(k);
    endtask

    // Feed n valid generator words, optionally with an idle cycle between each.
    task automatic feed(input int k, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) step(k, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
            step(k, 1'b1, g[k][4:1], 1'b0);
            g[k] = nx(g[k]);
        end
    endtask

    task automatic bad_word(input int k, input bit c);
        step(k, 1'b1, g[k][4:1] ^ rnd_mask(), c);
        g[k] = nx(g[k]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld0 = 0; vld1 = 0; clr0 = 0; clr1 = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        g[0] = GEN_SEED;
        g[1] = GEN_SEED;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare(0);
        compare(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean lock from seed 1f: locked after 2nd word, 100 words with no errors
        feed(0, 2, 1'b0);
        check("lock_after_2", 32'(locked0), 32'd1);
        check("next_pred_A", 32'(g[0][4:1]), 32'hA);
        feed(0, 98, 1'b0);
        check("clean_cnt", 32'(err_cnt0), 32'd0);

        // Single bit error on din[0]
        step(0, 1'b1, g[0][4:1] ^ 4'h1, 1'b0);
        g[0] = nx(g[0]);
        check("single_pulse", 32'(err_pulse0), 32'd1);
        check("single_cnt", 32'(err_cnt0), 32'd1);
        feed(0, 20, 1'b0);

        // Loss of sync after LOSS_THRESH consecutive wrong words
        step(0, 1'b1, g[0][4:1], 1'b1);
        g[0] = nx(g[0]);
        for (int i = 0; i < 4; i++) bad_word(0, 1'b0);
        check("loss_cnt", 32'(err_cnt0), 32'd4);
        check("loss_sl", 32'(sync_lost0), 32'd1);
        check("loss_locked", 32'(locked0), 32'd0);
        g[0] = 5'($urandom_range(1, 31));
        feed(0, 2, 1'b0);
        check("relock_2", 32'(locked0), 32'd1);
        feed(0, 10, 1'b0);

        // Asynchronous reset mid-stream clears outputs immediately
        bad_word(0, 1'b0);
        vld0 = 1'b1;
        din0 = g[0][4:1];
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked0), 32'd0);
        check("arst_pulse", 32'(err_pulse0), 32'd0);
        check("arst_sl", 32'(sync_lost0), 32'd0);
        check("arst_cnt", 32'(err_cnt0), 32'd0);
        model_reset();
        vld0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Zero rejection, then a gapped stream
        for (int i = 0; i < 10; i++) step(0, 1'b1, 4'h0, 1'b0);
        check("zero_nolock", 32'(locked0), 32'd0);
        g[0] = 5'($urandom_range(1, 31));
        feed(0, 30, 1'b1);
        check("gap_locked", 32'(locked0), 32'd1);

        // Mid-stream phase: start at word 17 of the seed-1f sequence
        pulse_reset();
        g[0] = GEN_SEED;
        for (int i = 0; i < 17; i++) g[0] = nx(g[0]);
        feed(0, 2, 1'b0);
        check("phase17_lock", 32'(locked0), 32'd1);
        feed(0, 30, 1'b0);
        check("phase17_cnt", 32'(err_cnt0), 32'd0);

        // Counter corner cases on the narrow instance
        g[1] = 5'($urandom_range(1, 31));
        feed(1, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bad_word(1, 1'b0);
            feed(1, 2, 1'b0);
        end
        check("sat_cnt", 32'(err_cnt1), 32'd3);
        bad_word(1, 1'b1);
        check("clr_with_err", 32'(err_cnt1), 32'd1);
        step(1, 1'b1, g[1][4:1], 1'b1);
        g[1] = nx(g[1]);
        check("clr_alone", 32'(err_cnt1), 32'd0);

        // Randomized traffic: gaps, isolated and burst errors, clears, phase jumps
        pulse_reset();
        g[0] = 5'($urandom_range(1, 31));
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20) begin
                step(0, 1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            end else if (r < 28) begin
                bad_word(0, ($urandom_range(0, 15) == 0));
            end else if (r < 30) begin
                for (int j = 0; j < 5; j++) bad_word(0, 1'b0);
            end else if (r < 31) begin
                g[0] = 5'($urandom_range(1, 31));
                step(0, 1'b1, g[0][4:1], 1'b0);
                g[0] = nx(g[0]);
            end else begin
                step(0, 1'b1, g[0][4:1], ($urandom_range(0, 31) == 0));
                g[0] = nx(g[0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
